mem_access_ctrl: RTL

- Memory-stage data-access controller; the producing end of the MEM/WB handshake.
- Issues read/write requests to the data cache for the instruction in MEM and waits for dhit.
- Captures load data into a held register (dload) and generates the pipeline-advance `enable` that the MEM/WB latch consumes.
- Latches halt and freezes the pipeline once a halting instruction reaches MEM.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/sat_counter.sv | 21 ++
 rtl/mem_access_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: types shared by the memory-stage control logic.
// Provides the memory-access FSM state enum, the machine word type and a
// helper that classifies an instruction as a data-memory operation.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE,
        HALTED
    } memctrl_state_t;

    // A bubble never touches memory, whatever its decoded read/write bits say.
    function automatic logic is_mem_op(input logic valid, input logic rd, input logic wr);
        return valid & (rd | wr);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping; clear has priority over inc.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, stop at all-ones, return to zero on clear.
    always_ff @(posedge CLK) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage data-access controller, producing end of the
// MEM/WB handshake. Issues one data-cache request per memory instruction,
// holds load data in dload, generates the pipeline-advance enable and latches
// halt once a HALT reaches MEM.
// Optional feature: define MEM_STALL_CNT_EN to add the stall_cnt output, a
// saturating count of cycles spent waiting on the cache or on fetch.
module mem_access_ctrl
    import cpu_types_pkg::*;
#(
    parameter int DATA_W      = WORD_W,
    parameter int ADDR_W      = WORD_W,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   valid_MEM,
    input  logic                   memRd_MEM,
    input  logic                   memWr_MEM,
    input  logic                   halt_MEM,
    input  logic [ADDR_W-1:0]      addr_MEM,
    input  logic [DATA_W-1:0]      storedata_MEM,
    input  logic                   fetch_ready,
    input  logic                   dhit,
    input  logic [DATA_W-1:0]      dmemload,
    output logic                   dmemREN,
    output logic                   dmemWEN,
    output logic [ADDR_W-1:0]      dmemaddr,
    output logic [DATA_W-1:0]      dmemstore,
    output logic [DATA_W-1:0]      dload,
    output logic                   enable,
    output logic                   halt
`ifdef MEM_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    if (STALL_CNT_W < 1) begin : g_bad_stall_w
        $error("STALL_CNT_W must be at least 1");
    end

    memctrl_state_t state;
    logic           mem_op;
    logic           rd_req;
    logic           unused_addr_bits;

    assign mem_op = is_mem_op(valid_MEM, memRd_MEM, memWr_MEM);
    // A store wins when both decode bits are set, so a read only counts alone.
    assign rd_req = memRd_MEM & ~memWr_MEM;

    // The cache is word addressed; byte offset bits are dropped here.
    assign dmemaddr         = {addr_MEM[ADDR_W-1:2], 2'b00};
    assign unused_addr_bits = ^addr_MEM[1:0];
    assign dmemstore        = storedata_MEM;
    assign halt             = (state == HALTED);

    // State register and load-data capture; dload moves only on a read hit.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            dload <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        state <= REQ;
                    end else if (valid_MEM && halt_MEM && fetch_ready) begin
                        state <= HALTED;
                    end
                end
                REQ: begin
                    if (dhit) begin
                        if (rd_req) begin
                            dload <= dmemload;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (fetch_ready) begin
                        state <= IDLE;
                    end
                end
                HALTED: state <= HALTED;
                default: state <= IDLE;
            endcase
        end
    end

    // Cache requests and pipeline advance decoded from the current state.
    // NOTE: every output gets a default first so always_comb cannot infer a latch.
    always_comb begin
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        enable  = 1'b0;
        case (state)
            IDLE: enable = fetch_ready & ~mem_op;
            REQ: begin
                dmemWEN = memWr_MEM;
                dmemREN = rd_req;
            end
            DONE: enable = fetch_ready;
            default: enable = 1'b0;
        endcase
        if (RST) begin
            enable = 1'b0;
        end
    end

`ifdef MEM_STALL_CNT_EN
    logic stall_inc;

    assign stall_inc = (state == REQ) || ((state == DONE) && !fetch_ready);

    sat_counter #(
        .W (STALL_CNT_W)
    ) u_stall_cnt (
        .CLK   (CLK),
        .clear (RST),
        .inc   (stall_inc),
        .count (stall_cnt)
    );
`endif

endmodule
